// File: rtl/node_comp_seq.sv
// Composition sequencer: starts N child nodes in parallel, latches each result as it arrives,
// then runs the outer function node on the collected results. A watchdog bounds every wait.
module node_comp_seq #(
  parameter int W   = 16,
  parameter int N   = 2,
  parameter int TMO = 1024
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           ST,
  output logic           RD,
  output logic [W-1:0]   RES,
  output logic           ERR,
  output logic [N-1:0]   CH_ST,
  input  logic [N-1:0]   CH_RD,
  input  logic [N*W-1:0] CH_RES,
  output logic           F_ST,
  input  logic           F_RD,
  input  logic [W-1:0]   F_RES,
  output logic [N*W-1:0] F_IN
);

  localparam int CW = $clog2(TMO);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE, CH_START, CH_WAIT, F_START, F_WAIT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic           st_old_q;
  logic           rd_q, rd_d;
  logic [W-1:0]   res_q, res_d;
  logic           err_q, err_d;
  logic [N-1:0]   ch_st_q, ch_st_d;
  logic           f_st_q, f_st_d;
  logic [N*W-1:0] f_in_q, f_in_d;
  logic [N-1:0]   seen_q, seen_d;
  logic [N-1:0]   done_q, done_d;
  logic           f_seen_q, f_seen_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           timeout;

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    res_d    = res_q;
    err_d    = err_q;
    ch_st_d  = ch_st_q;
    f_st_d   = f_st_q;
    f_in_d   = f_in_q;
    seen_d   = seen_q;
    done_d   = done_q;
    f_seen_d = f_seen_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        rd_d    = 1'b1;
        ch_st_d = '0;
        f_st_d  = 1'b0;
        if (ST && !st_old_q) begin
          rd_d    = 1'b0;
          err_d   = 1'b0;
          seen_d  = '0;
          done_d  = '0;
          state_d = CH_START;
        end
      end

      CH_START: begin
        ch_st_d = '1;
        cnt_d   = '0;
        state_d = CH_WAIT;
      end

      CH_WAIT: begin
        ch_st_d = '1;
        // A ready is only trusted after that child has been seen busy (low) once.
        for (int i = 0; i < N; i++) begin
          if (!CH_RD[i]) begin
            seen_d[i] = 1'b1;
          end else if (seen_q[i] && !done_q[i]) begin
            done_d[i]         = 1'b1;
            f_in_d[i*W +: W]  = CH_RES[i*W +: W];
          end
        end
        if (&done_d) begin
          ch_st_d = '0;
          state_d = F_START;
        end else if (timeout) begin
          err_d   = 1'b1;
          rd_d    = 1'b1;
          ch_st_d = '0;
          f_st_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      F_START: begin
        f_st_d   = 1'b1;
        cnt_d    = '0;
        f_seen_d = 1'b0;
        state_d  = F_WAIT;
      end

      F_WAIT: begin
        if (!F_RD) begin
          f_seen_d = 1'b1;
        end
        if (F_RD && f_seen_q) begin
          res_d   = F_RES;
          f_st_d  = 1'b0;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          rd_d    = 1'b1;
          ch_st_d = '0;
          f_st_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        rd_d    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    st_old_q <= ST;
    if (RST) begin
      state_q  <= IDLE;
      rd_q     <= 1'b1;
      res_q    <= '0;
      err_q    <= 1'b0;
      ch_st_q  <= '0;
      f_st_q   <= 1'b0;
      f_in_q   <= '0;
      seen_q   <= '0;
      done_q   <= '0;
      f_seen_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      err_q    <= err_d;
      ch_st_q  <= ch_st_d;
      f_st_q   <= f_st_d;
      f_in_q   <= f_in_d;
      seen_q   <= seen_d;
      done_q   <= done_d;
      f_seen_q <= f_seen_d;
      cnt_q    <= cnt_d;
    end
  end

  assign RD    = rd_q;
  assign RES   = res_q;
  assign ERR   = err_q;
  assign CH_ST = ch_st_q;
  assign F_ST  = f_st_q;
  assign F_IN  = f_in_q;

endmodule

// File: doc/node_comp_seq.md
Name: node_comp_seq

Overview:
- Composition sequencer for the function-tree evaluator: runs N child nodes in parallel, collects their results, then runs one outer function node on them.
- Uses the standard node start/ready handshake on both sides: rising edge of ST starts a node, and RD returning high means the result is valid.
- Upward it looks like an ordinary node (ST/RD/RES), so composed subtrees nest.
- Adds a watchdog so a hung child cannot hang the whole tree.

Parameters:
- W, 16, data width of every RES/IN word.
- N, 2, number of child nodes (1..8).
- TMO, 1024, maximum cycles allowed in any single wait state before abort (>=4).

Ports:
- CLK  input  1  clock, all logic on posedge.
- RST  input  1  reset; synchronous, active-high.
- ST  input  1  start request from parent; rising edge (ST=1, previous sample 0) triggers.
- RD  output  1  ready/done to parent; reset 1.
- RES  output  W  composed result; reset 0.
- ERR  output  1  set on watchdog abort; reset 0.
- CH_ST  output  N  start to each child; reset 0.
- CH_RD  input  N  ready from each child.
- CH_RES  input  N*W  child results, child i at bits [i*W+W-1 : i*W].
- F_ST  output  1  start to outer function node; reset 0.
- F_RD  input  1  ready from outer node.
- F_RES  input  W  outer node result.
- F_IN  output  N*W  registered child results feeding the outer node's IN0..IN(N-1); reset 0.

Behaviour:
- All outputs are registered. STold is a registered copy of ST, updated every cycle, including in reset and while busy.
- Reset (any state, mid-operation included):
  - state=IDLE, RD=1, RES=0, ERR=0.
  - CH_ST=0, F_ST=0, F_IN=0.
  - seen_low=0, done=0, watchdog counter=0.
- IDLE: RD=1, CH_ST=0, F_ST=0. On ST&~STold: RD<=0, ERR<=0, clear seen_low/done, go CH_START.
- CH_START: CH_ST<=all 1, counter<=0, go CH_WAIT.
- CH_WAIT: CH_ST held all 1. Per child i:
  - CH_RD[i]==0 sampled -> seen_low[i]<=1.
  - seen_low[i] && CH_RD[i]==1 && !done[i] -> done[i]<=1 and F_IN slice i<=CH_RES slice i, latched that cycle.
  - RD high before seen_low (stale ready) is ignored.
  - When every child is done (including one completing this cycle): CH_ST<=0, go F_START.
- F_START: F_ST<=1, counter<=0, seen_low/done for F cleared, go F_WAIT.
- F_WAIT: same low-then-high detection on F_RD. On completion: RES<=F_RES, F_ST<=0, go DONE.
- DONE: RD<=1, go IDLE. RES then holds until the next completed run.
- Watchdog (CH_WAIT, F_WAIT):
  - Counter increments each cycle in the wait state.
  - At counter==TMO-1 without completion: ERR<=1, RD<=1, CH_ST<=0, F_ST<=0, go IDLE. RES keeps its old value.
- ST rising edges outside IDLE are ignored, not queued. ST held high after completion does not retrigger.
- Latency with ideal nodes (RD low 2 cycles after start): RD falls at the posedge sampling the ST edge (E0) and rises at E0+11.
- Children finishing in different cycles: each is latched independently. The outer start waits for the slowest child.
- A child may leave RD low arbitrarily long; only the watchdog bounds it.

Test Plan:
- Reset then idle: RST=1 for 2 cycles -> RD=1, RES=0, ERR=0, CH_ST=0, F_ST=0. Hold ST=1 after reset with STold=1 -> no start.
- Basic run, N=2, W=16: children are ideal identity nodes returning 0x0003 and 0x0005; outer node is an adder model. Pulse ST -> RD low at E0, RD high at E0+11, RES=0x0008, F_IN={0x0005,0x0003}, ERR=0.
- Skewed children: child 1 keeps RD low 20 extra cycles -> F_ST rises only after child 1 done, F_IN slice 0 latched earlier and unchanged, RES correct.
- Busy retrigger: toggle ST 0->1->0->1 during CH_WAIT -> exactly one run, RD rises once, no extra CH_ST edge.
- Watchdog: TMO=16, child 0 never raises RD -> 16 cycles in CH_WAIT, then ERR=1, RD=1, CH_ST=0, RES unchanged. Next ST edge clears ERR and the run completes normally.
- Reset mid-F_WAIT: assert RST while F_ST=1 -> next cycle F_ST=0, RD=1, RES=0. A following ST edge produces a correct result.
